pwm_ramp_ctrl: RTL and testbench

Multi-channel LED PWM controller with soft duty ramping. It sits between the Nios PIO/key logic and the LEDR pins inside the PWM control top. Requesters write per-channel target duties over a valid/ready port. The block owns one shared prescaler and PWM counter, and sequences each channel's active duty toward its target at PWM period boundaries.

---
 rtl/pwm_ramp_pkg.sv | 15 +
 rtl/pwm_ramp_step.sv | 33 +++
 rtl/pwm_ramp_ctrl.sv | 145 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_pkg.sv
// Shared types and default sizing for the LED PWM ramp controller.
package pwm_ramp_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SCAN
    } state_e;

    localparam int DEF_CH       = 10;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_PRESC    = 195;
    localparam int DEF_STEP     = 4;
    localparam int DEF_RAMP_DIV = 4;

endpackage

// File: rtl/pwm_ramp_step.sv
// Clamped single ramp step: moves cur toward tgt by at most STEP, never past tgt.
module pwm_ramp_step #(
    parameter int CNT_W = 8,
    parameter int STEP  = 4
) (
    input  logic [CNT_W-1:0] cur_i,
    input  logic [CNT_W-1:0] tgt_i,
    output logic [CNT_W-1:0] nxt_o
);

    localparam int STEP_C = (STEP > (1 << CNT_W)) ? (1 << CNT_W) : STEP;
    localparam logic [CNT_W:0] STEP_X = (CNT_W+1)'(STEP_C);

    logic [CNT_W:0] cur_x, tgt_x, up_gap, dn_gap, up_x, dn_x;

    // One extra bit so a full-scale STEP and the gaps never wrap.
    assign cur_x  = {1'b0, cur_i};
    assign tgt_x  = {1'b0, tgt_i};
    assign up_gap = tgt_x - cur_x;
    assign dn_gap = cur_x - tgt_x;
    assign up_x   = cur_x + STEP_X;
    assign dn_x   = cur_x - STEP_X;

    always_comb begin
        nxt_o = cur_i;
        if (tgt_x > cur_x) begin
            nxt_o = (up_gap > STEP_X) ? up_x[CNT_W-1:0] : tgt_i;
        end else if (tgt_x < cur_x) begin
            nxt_o = (dn_gap > STEP_X) ? dn_x[CNT_W-1:0] : tgt_i;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Multi-channel LED PWM with per-channel target duties applied at period boundaries.
// Define PWM_RAMP_CTRL_RAMP_EN for soft ramping (STEP/RAMP_DIV); otherwise targets jump directly.
module pwm_ramp_ctrl
    import pwm_ramp_pkg::*;
#(
    parameter int CH       = DEF_CH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PRESC    = DEF_PRESC,
    parameter int STEP     = DEF_STEP,
    parameter int RAMP_DIV = DEF_RAMP_DIV,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [CH_W-1:0]  WR_CH,
    input  logic [CNT_W-1:0] WR_DUTY,
    output logic [CH-1:0]    PWM_OUT,
    output logic             PERIOD_START,
    output logic             BUSY
);

    localparam int PR_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CH);

    if (CH < 1 || PRESC < 1 || STEP < 1 || RAMP_DIV < 1 ||
        PRESC * (2 ** CNT_W) <= CH + 1) begin : g_bad_params
        $error("pwm_ramp_ctrl: invalid parameter set");
    end

    logic [PR_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick, bnd, scan_go, scan_we, wr_fire;

    logic [CH-1:0][CNT_W-1:0] tgt_q, cur_q, act_q;
    logic [CH-1:0]            pwm_q;
    logic                     busy_q;
    logic [CNT_W-1:0]         nxt_cur;

    state_e          state_q, state_d;
    logic [CH_W-1:0] idx_q, idx_d;

    assign tick    = (presc_q == PR_W'(PRESC - 1));
    assign bnd     = tick && (cnt_q == '1);
    assign presc_d = tick ? '0 : presc_q + PR_W'(1);
    assign cnt_d   = tick ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PWM_RAMP_CTRL_RAMP_EN
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [DIV_W-1:0] div_q, div_d;

    // Divider at zero on a boundary means this boundary triggers a ramp scan.
    assign scan_go = bnd && (div_q == '0);
    assign div_d   = !bnd ? div_q :
                     (div_q == '0) ? DIV_W'(RAMP_DIV - 1) : div_q - DIV_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) div_q <= '0;
        else     div_q <= div_d;
    end

    pwm_ramp_step #(
        .CNT_W (CNT_W),
        .STEP  (STEP)
    ) u_step (
        .cur_i (cur_q[idx_q]),
        .tgt_i (tgt_q[idx_q]),
        .nxt_o (nxt_cur)
    );
`else
    assign scan_go = bnd;
    assign nxt_cur = tgt_q[idx_q];
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        scan_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (scan_go) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                scan_we = 1'b1;
                if (idx_q == CH_W'(CH - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Out-of-range channel writes complete the handshake but touch nothing.
    assign WR_READY = !RST && (state_q == ST_IDLE);
    assign wr_fire  = WR_VALID && WR_READY && ({1'b0, WR_CH} < CH_LIM);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tgt_q  <= '0;
            cur_q  <= '0;
            act_q  <= '0;
            pwm_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            if (wr_fire) tgt_q[WR_CH] <= WR_DUTY;
            if (scan_we) cur_q[idx_q] <= nxt_cur;
            if (bnd)     act_q        <= cur_q;
            for (int i = 0; i < CH; i++) pwm_q[i] <= (cnt_q < act_q[i]);
            busy_q <= (cur_q != tgt_q);
        end
    end

    assign PWM_OUT      = pwm_q;
    assign PERIOD_START = bnd;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed table of write/observe records plus random writes,
// all checked against a period-level model of targets, ramped duties and applied duties.
module tb_pwm_ramp_ctrl;

    // CH=5 so that channel index 5 fits the 3-bit WR_CH port and is genuinely out of range.
    localparam int CH       = 5;
    localparam int CNT_W    = 4;
    localparam int PRESC    = 2;
    localparam int STEP     = 4;
    localparam int RAMP_DIV = 1;
    localparam int CH_W     = $clog2(CH);
    localparam int NTICK    = 1 << CNT_W;
    localparam int PERIOD   = PRESC * NTICK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0;
    logic [CH_W-1:0]  wr_ch = '0;
    logic [CNT_W-1:0] wr_duty = '0;
    logic             WR_READY, PERIOD_START, BUSY;
    logic [CH-1:0]    PWM_OUT;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .CH(CH), .CNT_W(CNT_W), .PRESC(PRESC), .STEP(STEP), .RAMP_DIV(RAMP_DIV)
    ) dut (
        .CLK(clk), .RST(rst), .WR_VALID(wr_valid), .WR_READY(WR_READY),
        .WR_CH(wr_ch), .WR_DUTY(wr_duty), .PWM_OUT(PWM_OUT),
        .PERIOD_START(PERIOD_START), .BUSY(BUSY)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: cycles since reset, boundaries seen, duty arrays, cycles of SCAN left.
    int n, nb, lowcnt;
    int tgt_m[CH], cur_m[CH], act_m[CH];

    task automatic model_reset();
        n = 0; nb = 0; lowcnt = 0;
        for (int i = 0; i < CH; i++) begin
            tgt_m[i] = 0; cur_m[i] = 0; act_m[i] = 0;
        end
    endtask

    function automatic int approach(input int c, input int t);
`ifdef PWM_RAMP_CTRL_RAMP_EN
        if (t - c > STEP) return c + STEP;
        if (c - t > STEP) return c - STEP;
`endif
        return t;
    endfunction

    function automatic bit scan_now(input int b);
`ifdef PWM_RAMP_CTRL_RAMP_EN
        return (b % RAMP_DIV) == 0;
`else
        return 1'b1;
`endif
    endfunction

    // One clock: model the edge from the driven inputs, then compare just after the edge.
    task automatic cyc(output bit acc);
        int cnt_b;
        bit bnd, rdy, bchk, be;
        logic [CH-1:0] pe;
        cnt_b = (n / PRESC) % NTICK;
        bnd   = (n % PERIOD) == PERIOD - 1;
        rdy   = (lowcnt == 0);
        for (int i = 0; i < CH; i++) pe[i] = (cnt_b < act_m[i]);
        bchk = rdy;
        be = 1'b0;
        for (int i = 0; i < CH; i++) if (cur_m[i] != tgt_m[i]) be = 1'b1;
        acc = wr_valid && rdy;
        if (acc && wr_ch < CH) tgt_m[wr_ch] = wr_duty;
        if (lowcnt > 0) lowcnt--;
        if (bnd) begin
            for (int i = 0; i < CH; i++) act_m[i] = cur_m[i];
            if (scan_now(nb)) begin
                lowcnt = CH;
                for (int i = 0; i < CH; i++) cur_m[i] = approach(cur_m[i], tgt_m[i]);
            end
            nb++;
        end
        n++;
        @(posedge clk);
        #1;
        chk("pwm_out", PWM_OUT, pe);
        chk("wr_ready", WR_READY, lowcnt == 0);
        chk("period_start", PERIOD_START, (n % PERIOD) == PERIOD - 1);
        if (bchk) chk("busy", BUSY, be);
    endtask

    task automatic wait_ps();
        bit a;
        int k;
        k = 0;
        do begin
            cyc(a);
            k++;
        end while (PERIOD_START !== 1'b1 && k < 2 * PERIOD);
        if (PERIOD_START !== 1'b1) chk("period_start_timeout", 0, 1);
    endtask

    task automatic do_write(input int ch, input int duty);
        bit a;
        int k;
        k = 0;
        while ((WR_READY !== 1'b1 || PERIOD_START === 1'b1) && k < 4 * CH) begin
            cyc(a);
            k++;
        end
        if (WR_READY !== 1'b1) chk("write_ready_timeout", 0, 1);
        wr_valid = 1'b1;
        wr_ch    = CH_W'(ch);
        wr_duty  = CNT_W'(duty);
        cyc(a);
        wr_valid = 1'b0;
    endtask

    typedef struct {
        int wr_ch;
        int duty;
        int obs_ch;
        int exp_ticks[4];
    } vec_t;

    vec_t tbl[6];

    initial begin
        bit a;
        int k, hc, lowc;

        $display("tb_pwm_ramp_ctrl: CH=%0d CNT_W=%0d PRESC=%0d STEP=%0d RAMP_DIV=%0d",
                 CH, CNT_W, PRESC, STEP, RAMP_DIV);

        // High-tick counts for the four periods that start at the second boundary after the write.
`ifdef PWM_RAMP_CTRL_RAMP_EN
        tbl[0] = '{1, 12, 1, '{4, 8, 12, 12}};
        tbl[1] = '{2, 15, 2, '{4, 8, 12, 15}};
        tbl[2] = '{2, 2,  2, '{11, 7, 3, 2}};
        tbl[5] = '{0, 9,  0, '{4, 8, 9, 9}};
`else
        tbl[0] = '{1, 12, 1, '{12, 12, 12, 12}};
        tbl[1] = '{2, 15, 2, '{15, 15, 15, 15}};
        tbl[2] = '{2, 2,  2, '{2, 2, 2, 2}};
        tbl[5] = '{0, 9,  0, '{9, 9, 9, 9}};
`endif
        tbl[3] = '{3, 0, 3, '{0, 0, 0, 0}};
        tbl[4] = '{5, 9, 1, '{12, 12, 12, 12}};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm", PWM_OUT, 0);
        chk("rst_period_start", PERIOD_START, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", WR_READY, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", WR_READY, 1);

        // Idle: period pulse spacing
        wait_ps();
        k = 0;
        do begin
            cyc(a);
            k++;
        end while (PERIOD_START !== 1'b1 && k < 2 * PERIOD);
        chk("ps_spacing", k, PERIOD);
        repeat (8) cyc(a);

        // Table-driven write / observe records
        foreach (tbl[e]) begin
            do_write(tbl[e].wr_ch, tbl[e].duty);
            wait_ps();
            wait_ps();
            cyc(a);
            for (int p = 0; p < 4; p++) begin
                hc = 0;
                for (int c = 0; c < PERIOD; c++) begin
                    cyc(a);
                    hc += int'(PWM_OUT[tbl[e].obs_ch]);
                end
                chk($sformatf("tbl%0d_period%0d_high_cycles", e, p), hc,
                    tbl[e].exp_ticks[p] * PRESC);
            end
        end

        // Write held valid across a boundary: READY low for CH cycles, then accepted.
        repeat (4) cyc(a);
        wait_ps();
        cyc(a);
        wr_valid = 1'b1;
        wr_ch    = CH_W'(4);
        wr_duty  = CNT_W'(7);
        lowc = 0;
        while (WR_READY !== 1'b1 && lowc < 4 * CH) begin
            cyc(a);
            lowc++;
        end
        chk("ready_low_cycles", lowc, CH);
        cyc(a);
        chk("held_write_accepted", a, 1);
        wr_valid = 1'b0;
        cyc(a);
        chk("busy_after_held_write", BUSY, 1);

        // Random writes
        for (int r = 0; r < 1500; r++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_ch    = CH_W'($urandom_range(0, 7));
            wr_duty  = CNT_W'($urandom_range(0, NTICK - 1));
            cyc(a);
        end
        wr_valid = 1'b0;

        // Reset asserted in the middle of a SCAN
        do_write(0, 15);
        wait_ps();
        cyc(a);
        cyc(a);
        rst = 1'b1;
        #1;
        chk("midscan_rst_pwm", PWM_OUT, 0);
        chk("midscan_rst_busy", BUSY, 0);
        chk("midscan_rst_ready", WR_READY, 0);
        chk("midscan_rst_ps", PERIOD_START, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("ready_after_midscan_rst", WR_READY, 1);
        hc = 0;
        for (int c = 0; c < 2 * PERIOD; c++) begin
            cyc(a);
            hc += $countones(PWM_OUT);
        end
        chk("pwm_quiet_after_rst", hc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
